// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, fetch state encoding, queue entry type and instruction field positions
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_W   = 3;
    localparam int OPRAND_LSB = 25;
    localparam int OPRAND_W   = 7;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } fetch_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched entries with flush, registered head and occupancy count
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output logic [CW-1:0] count_o,
    output logic         valid_o,
    output fetch_entry_t head_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && count_q != '0;
    assign do_push = push_i && (count_q != CW'(DEPTH) || do_pop);
    assign count_o = count_q;
    assign valid_o = count_q != '0;
    assign head_o  = mem_q[rd_q];

    // storage and pointers; flush empties the queue and overrides push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction fetcher feeding decode; FETCH_ALIGN_CHECK_EN turns misaligned redirects into a faulting NOP and HALT
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  oprand
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d, req_pc_q, req_pc_d;
    logic          live_q;
    logic [CW-1:0] count;
    logic          space, req_fire, in_flight, push, pop, misaligned;
    logic [31:0]   target;
    fetch_entry_t  push_data, head;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target     = redirect_pc;
    assign misaligned = pc_q[1:0] != 2'b00;
`else
    assign target     = redirect_pc & ~32'h3;
    assign misaligned = 1'b0;
`endif

    // only one request is ever outstanding, so nothing is reserved while in REQ
    assign space          = count < CW'(QUEUE_DEPTH);
    assign imem_req_valid = live_q && state_q == ST_REQ && !misaligned && space;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign in_flight      = req_fire || ((state_q == ST_WAIT || state_q == ST_DROP) && !imem_rsp_valid);
    assign pop            = inst_valid && inst_ready && !redirect_valid;

    // next-state, PC and queue push selection; redirect overrides everything
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        push      = 1'b0;
        push_data = '{inst: imem_rsp_data, pc: req_pc_q, err: imem_rsp_err};
        if (redirect_valid) begin
            pc_d    = target;
            state_d = in_flight ? ST_DROP : ST_REQ;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (req_fire) begin
                        pc_d     = next_pc(pc_q);
                        req_pc_d = pc_q;
                        state_d  = ST_WAIT;
                    end
`ifdef FETCH_ALIGN_CHECK_EN
                    else if (misaligned && space) begin
                        push      = 1'b1;
                        push_data = '{inst: NOP, pc: pc_q, err: 1'b1};
                        state_d   = ST_HALT;
                    end
`endif
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        push    = 1'b1;
                        state_d = ST_REQ;
                    end
                end
                ST_DROP: state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
                default: state_d = state_q;
            endcase
        end
    end

    // fetch state, PC, address of the outstanding request and post-reset enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            live_q   <= 1'b1;
        end
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect_valid),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (pop),
        .count_o    (count),
        .valid_o    (inst_valid),
        .head_o     (head)
    );

    assign inst     = head.inst;
    assign inst_pc  = head.pc;
    assign inst_err = head.err;
    assign opcode   = head.inst[OPCODE_LSB +: OPCODE_W];
    assign funct3   = head.inst[FUNCT3_LSB +: FUNCT3_W];
    assign oprand   = head.inst[OPRAND_LSB +: OPRAND_W];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic against an address-stream reference model with a decoupled scoreboard
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0, imem_rsp_err = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid, inst_ready = 1'b0, inst_err;
    logic [31:0] inst, inst_pc;
    logic [6:0]  opcode, oprand;
    logic [2:0]  funct3;

    fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_err(inst_err), .opcode(opcode), .funct3(funct3), .oprand(oprand)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;
    logic [31:0] gen_pc, req_next, hs_addr, rsp_addr, pend_tgt, redir_tgt;
    bit halted, req_halt, hs_seen, prev_redir, pending_redir;
    int hs_total = 0, idle = 0, rsp_cnt = 0;
    int lat_min = 1, lat_max = 1, ready_pct = 100, iready_pct = 100, redir_pct = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_5A5A;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[5:2] == 4'd2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        while (!halted && exp_q.size() < 8) begin
            exp_q.push_back('{inst: mem_word(gen_pc), pc: gen_pc, err: mem_err(gen_pc)});
            gen_pc += 32'd4;
        end
    endtask

    // the delivered stream restarts at the target; misaligned targets either round down or fault
    task automatic redirect_model(input logic [31:0] t);
        exp_q.delete();
        halted = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        if (t[1:0] != 2'b00) begin
            exp_q.push_back('{inst: NOP, pc: t, err: 1'b1});
            halted = 1'b1;
        end else begin
            gen_pc = t;
            refill();
        end
`else
        gen_pc = t & ~32'h3;
        refill();
`endif
    endtask

    function automatic logic [31:0] pick_target();
        int r = $urandom_range(9);
        if (r == 0) return 32'hFFFF_FFF8;
        if (r == 1) return RPC | ($urandom & 32'hFFC) | 32'($urandom_range(3));
        return RPC | ($urandom & 32'hFFC);
    endfunction

    // one clock of stimulus: memory responder, handshakes and optional redirect
    task automatic step();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (hs_seen) begin
            rsp_cnt  = $urandom_range(lat_max, lat_min);
            rsp_addr = hs_addr;
            hs_seen  = 1'b0;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        imem_rsp_data  = '0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(rsp_addr);
                imem_rsp_err   = mem_err(rsp_addr);
            end
        end
        imem_req_ready = $urandom_range(99) < ready_pct;
        inst_ready     = $urandom_range(99) < iready_pct;
        if (pending_redir || $urandom_range(99) < redir_pct) begin
            redir_tgt      = pending_redir ? pend_tgt : pick_target();
            pending_redir  = 1'b0;
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
            redirect_model(redir_tgt);
        end
        refill();
    endtask

    task automatic model_reset();
        rsp_cnt = 0; hs_seen = 1'b0; prev_redir = 1'b0; idle = 0;
        req_next = RPC; req_halt = 1'b0; halted = 1'b0;
        exp_q.delete(); gen_pc = RPC; refill();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // monitor: request address model, one-outstanding rule, scoreboard of delivered entries, progress watchdog
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (prev_redir) check("flush_inst_valid", inst_valid, 0);
            prev_redir = redirect_valid;
            if (imem_req_valid) begin
                check("one_outstanding", rsp_cnt != 0 || imem_rsp_valid, 0);
                if (imem_req_ready) begin
                    hs_total++;
                    idle = 0;
                    check("req_addr", imem_req_addr, req_next);
                    check("req_while_halted", req_halt, 0);
                    hs_seen  = 1'b1;
                    hs_addr  = imem_req_addr;
                    req_next = imem_req_addr + 32'd4;
                end
            end
            if (redirect_valid) begin
                req_next = redirect_pc & ~32'h3;
`ifdef FETCH_ALIGN_CHECK_EN
                req_halt = redirect_pc[1:0] != 2'b00;
`endif
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry: got pc %08h expected none", inst_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("inst", inst, mon_e.inst);
                    check("inst_pc", inst_pc, mon_e.pc);
                    check("inst_err", inst_err, mon_e.err);
                    check("opcode", opcode, mon_e.inst[6:0]);
                    check("funct3", funct3, mon_e.inst[14:12]);
                    check("oprand", oprand, mon_e.inst[31:25]);
                end
            end
            if (inst_ready && !req_halt) idle++;
            if (idle > 40) begin
                checks++;
                errors++;
                $display("FAIL progress: got %0d idle cycles expected at most 40", idle);
                idle = 0;
            end
        end
    end

    int base;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_inst_err", inst_err, 0);
        check("rst_opcode", opcode, 0);
        check("rst_funct3", funct3, 0);
        check("rst_oprand", oprand, 0);
        rst_n = 1'b1;

        step();
        @(negedge clk);
        #1;
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr", imem_req_addr, RPC);
        repeat (30) step();

        iready_pct = 0;
        do_reset();
        base = hs_total;
        repeat (15) step();
        @(negedge clk);
        #1;
        check("full_req_count", hs_total - base, 2);
        check("full_req_valid", imem_req_valid, 0);
        check("head_pc", inst_pc, RPC);
        repeat (3) step();
        @(negedge clk);
        #1;
        check("head_stable_pc", inst_pc, RPC);
        check("head_stable_inst", inst, mem_word(RPC));
        iready_pct = 100;
        repeat (10) step();

        lat_min = 3; lat_max = 3;
        base = hs_total;
        for (int i = 0; i < 20 && hs_total == base; i++) begin
            step();
            @(negedge clk);
            #1;
        end
        pend_tgt = 32'h8000_0100; pending_redir = 1'b1;
        repeat (20) step();

        lat_min = 1; lat_max = 1;
        base = hs_total;
        for (int i = 0; i < 20 && hs_total == base; i++) begin
            step();
            @(negedge clk);
            #1;
        end
        pend_tgt = 32'h8000_0200; pending_redir = 1'b1;
        step();
        step();
        @(negedge clk);
        #1;
        check("rsp_redir_req_valid", imem_req_valid, 1);
        check("rsp_redir_req_addr", imem_req_addr, 32'h8000_0200);
        repeat (15) step();

        pend_tgt = 32'h8000_0102; pending_redir = 1'b1;
        repeat (15) step();
        pend_tgt = 32'h8000_0200; pending_redir = 1'b1;
        repeat (15) step();

        lat_min = 1; lat_max = 3; ready_pct = 70; iready_pct = 75; redir_pct = 4;
        repeat (2000) step();

        redir_pct = 0; ready_pct = 100; iready_pct = 100;
        repeat (30) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
